pipelined_addsub: RTL and testbench
===================================

Name: pipelined_addsub

Overview:
- Parametrised, multi-stage pipelined adder/subtractor. It generalises the fixed 16-bit pipelined ripple adder to any width, any stage count and a per-operation add/sub mode.
- Adds a valid/ready handshake with backpressure and a signed-overflow flag.
- Sits between operand producers and result consumers in datapath experiments. Benches instantiate it directly.

Parameters:
- SIZE, 16, operand/result width in bits.
- STAGES, 4, number of pipeline stages. Must divide SIZE exactly. CHUNK = SIZE/STAGES bits are processed per stage.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operands present this cycle.
- in_ready  out  1  block accepts operands this cycle.
- a  in  SIZE  operand A.
- b  in  SIZE  operand B.
- cin  in  1  carry-in when adding, borrow-in when subtracting.
- sub  in  1  0 = add, 1 = subtract.
- s  out  SIZE  result.
- cout  out  1  carry out of the MSB.
- ovf  out  1  two's-complement signed overflow.
- out_valid  out  1  s/cout/ovf hold a valid result.
- out_ready  in  1  consumer accepts the result this cycle.

Behaviour:
- Reset: the clock is clk; reset is synchronous and active-high on rst. While rst=1 at a clk edge:
  - all stage valid bits clear;
  - s=0, cout=0, ovf=0, out_valid=0;
  - all skew/deskew registers clear.
  - in_ready=1 in the cycle after reset.
  - Reset mid-operation discards every in-flight result; nothing emerges afterwards.
- Operand preparation at capture:
  - b' = sub ? ~b : b
  - c0 = cin ^ sub
  - sub=0: s = a + b + cin.
  - sub=1: s = a - b - cin (cin acts as borrow-in).
  - All arithmetic is modulo 2^SIZE.
- Pipeline structure:
  - Stage k (k = 0..STAGES-1) adds chunk k of a and b' plus the carry registered from stage k-1 (c0 for k=0).
  - Stage k registers its CHUNK-bit partial sum and carry-out.
  - Upper chunks travel through input skew registers, so chunk k is summed in stage k.
  - Lower partial sums travel through deskew registers, so all chunks of one operation reach the output register together.
  - Only one CHUNK-bit ripple lies between registers.
- Latency: exactly STAGES cycles from an accepted input (in_valid & in_ready at edge N) to out_valid=1 after edge N+STAGES-1, assuming no stall.
  - Throughput is one operation per cycle.
  - STAGES=1 gives a single registered full-width adder.
- Output flags:
  - cout is the carry out of the final stage.
  - ovf = carry into MSB XOR carry out of MSB. Compute it from the top chunk's internal carries.
- Handshake:
  - Global advance enable: adv = ~out_valid | out_ready.
  - in_ready = adv (combinational).
  - When adv=0, every pipeline register, valid bit and output holds.
  - When adv=1, all registers shift one stage. A stage with no valid input loads valid=0 (bubble).
  - An input offered while in_ready=0 is not captured. The producer holds it.
- Result stability: while out_valid=1 and out_ready=0, s/cout/ovf/out_valid are stable.
- Simultaneous out_ready=1 and in_valid=1 with a full pipe: the result retires and the new input enters in the same cycle. No bubble is inserted.
- Bubble values: s/cout/ovf of a bubble are don't-care to the consumer. The RTL drives the shifted register contents.

Test Plan (SIZE=16, STAGES=4, out_ready=1 unless stated):
1. Reset: assert rst mid-stream with 3 ops in flight -> out_valid=0, s=0, cout=0, ovf=0 next cycle. No result appears in the following 8 cycles.
2. Streaming add: back-to-back 0+0, 1+1, 14+11, 300+300, cin=0 -> results 0, 2, 25, 600 on four consecutive cycles, the first 4 cycles after acceptance.
3. Carry/overflow:
   - FFFF+FFFF -> s=FFFE, cout=1, ovf=0.
   - FFFF+8000 -> s=7FFF, cout=1, ovf=1.
   - 7FFF+0001 -> s=8000, cout=0, ovf=1.
4. Subtract:
   - sub=1: 0005-0003 -> s=0002, cout=1.
   - sub=1: 0003-0005 -> s=FFFE, cout=0.
   - sub=1, cin=1: 0005-0003 -> s=0001.
   - sub=1: 8000-0001 -> s=7FFF, ovf=1.
5. Backpressure: stream 6 ops and drop out_ready for 5 cycles once the pipe is full -> in_ready=0 during the stall, outputs frozen. All 6 results arrive in order with none lost or duplicated.
6. Parameter sweep: SIZE=8, STAGES=1/2/8 and SIZE=32, STAGES=4 with 1000 random ops each against a reference model -> zero mismatches, latency = STAGES.

Source files
------------

// File: rtl/pipelined_addsub.sv
// ---------------------------------------------------------------------------
// pipelined_addsub
//
// Parametrised pipelined adder/subtractor with a valid/ready handshake.
// The SIZE-bit operation is split into STAGES chunks of CHUNK = SIZE/STAGES
// bits. Stage k adds chunk k, so only one CHUNK-bit ripple sits between
// registers. The whole pipe advances on one global enable, which gives
// backpressure from the consumer straight through to the producer.
//
// SIZE must be an exact multiple of STAGES.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   in_valid   operands present this cycle
//   in_ready   block accepts operands this cycle (combinational)
//   a, b       SIZE-bit operands
//   cin        carry-in when adding, borrow-in when subtracting
//   sub        0 = a + b + cin, 1 = a - b - cin
//   s          SIZE-bit result
//   cout       carry out of the MSB
//   ovf        two's-complement signed overflow
//   out_valid  s/cout/ovf hold a valid result
//   out_ready  consumer accepts the result this cycle
// ---------------------------------------------------------------------------
module pipelined_addsub #(
   parameter int SIZE   = 16,
   parameter int STAGES = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [SIZE-1:0] a,
   input  logic [SIZE-1:0] b,
   input  logic            cin,
   input  logic            sub,
   output logic [SIZE-1:0] s,
   output logic            cout,
   output logic            ovf,
   output logic            out_valid,
   input  logic            out_ready
);

   localparam int CHUNK = SIZE / STAGES;

   logic            adv;
   logic [SIZE-1:0] b_prep;
   logic            c0;
   logic            ovf_q;

   // The pipe only moves when the output register is empty or being drained,
   // so a stalled consumer freezes every stage at once.
   assign adv      = ~out_valid | out_ready;
   assign in_ready = adv;

   // Subtraction is a + ~b + 1; a borrow-in removes that +1, hence cin ^ sub.
   assign b_prep = sub ? ~b : b;
   assign c0     = cin ^ sub;

   // Each stage carries one packed word laid out, from LSB upwards, as
   //   [finished sum chunks | remaining a chunks | remaining b' chunks]
   // Entering stage k, the a field starts at bit k*CHUNK and the b' field at
   // bit SIZE, so chunk k of both operands sits at fixed offsets. Each stage
   // overwrites a-chunk k with its partial sum and drops b'-chunk k, which
   // makes the word CHUNK bits narrower per stage. The last stage's word is
   // exactly the SIZE-bit result, so the skew and deskew registers are just
   // the untouched fields of these words.
   genvar k;
   for (k = 0; k < STAGES; k++) begin : g_st
      localparam int LO     = k * CHUNK;
      localparam int DW_IN  = 2 * SIZE - k * CHUNK;
      localparam int DW_OUT = DW_IN - CHUNK;

      logic [DW_IN-1:0]  din;
      logic              carry_in;
      logic              valid_in;
      logic [CHUNK-1:0]  psum;
      logic              pcarry;
      logic [DW_OUT-1:0] dnext;
      logic [DW_OUT-1:0] data_q;
      logic              carry_q;
      logic              valid_q;

      if (k == 0) begin : g_src
         assign din      = {b_prep, a};
         assign carry_in = c0;
         assign valid_in = in_valid;
      end else begin : g_src
         assign din      = g_st[k-1].data_q;
         assign carry_in = g_st[k-1].carry_q;
         assign valid_in = g_st[k-1].valid_q;
      end

      assign {pcarry, psum} = {1'b0, din[LO +: CHUNK]}
                            + {1'b0, din[SIZE +: CHUNK]}
                            + {{CHUNK{1'b0}}, carry_in};

      // Repack the word: lower sums and upper a bits keep their positions,
      // chunk k becomes the new partial sum, and the remaining b' bits
      // slide down by one chunk to close the gap left by b'-chunk k.
      always_comb begin
         dnext = '0;
         for (int i = 0; i < SIZE; i++) begin
            dnext[i] = din[i];
         end
         dnext[LO +: CHUNK] = psum;
         for (int i = SIZE; i < DW_OUT; i++) begin
            dnext[i] = din[i + CHUNK];
         end
      end

      // Stage register. A stage fed by a bubble still shifts its data but
      // loads valid = 0.
      always_ff @(posedge clk) begin
         if (rst) begin
            data_q  <= '0;
            carry_q <= 1'b0;
            valid_q <= 1'b0;
         end else if (adv) begin
            data_q  <= dnext;
            carry_q <= pcarry;
            valid_q <= valid_in;
         end
      end

      // Carry into the MSB is recovered from the MSB sum bit
      // (s = a ^ b' ^ c_in), then XORed with the carry out of the MSB.
      if (k == STAGES - 1) begin : g_ovf
         logic carry_into_msb;

         assign carry_into_msb = din[LO + CHUNK - 1]
                               ^ din[SIZE + CHUNK - 1]
                               ^ psum[CHUNK-1];

         always_ff @(posedge clk) begin
            if (rst) begin
               ovf_q <= 1'b0;
            end else if (adv) begin
               ovf_q <= carry_into_msb ^ pcarry;
            end
         end
      end
   end

   assign s         = g_st[STAGES-1].data_q;
   assign cout      = g_st[STAGES-1].carry_q;
   assign out_valid = g_st[STAGES-1].valid_q;
   assign ovf       = ovf_q;

endmodule

// File: tb/tb_pipelined_addsub.sv
// ---------------------------------------------------------------------------
// tb_pipelined_addsub
//
// Self-checking bench for pipelined_addsub. A 16-bit/4-stage instance gets
// directed reset, streaming, carry/overflow, subtract and backpressure
// sequences. Four more instances (8/1, 8/2, 8/8, 32/4) share one random
// stimulus stream and are scored against an arithmetic reference model.
// ---------------------------------------------------------------------------
module tb_pipelined_addsub;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // Main 16-bit / 4-stage instance
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] a;
   logic [15:0] b;
   logic        cin;
   logic        sub;
   logic [15:0] s;
   logic        cout;
   logic        ovf;
   logic        out_valid;
   logic        out_ready;

   pipelined_addsub #(.SIZE(16), .STAGES(4)) u_dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .cin(cin), .sub(sub), .s(s), .cout(cout), .ovf(ovf),
      .out_valid(out_valid), .out_ready(out_ready)
   );

   // Parameter-sweep instances sharing one stimulus stream
   logic        sw_rst;
   logic        sw_in_valid;
   logic        sw_out_ready;
   logic        sw_cin;
   logic        sw_sub;
   logic [31:0] sw_a;
   logic [31:0] sw_b;
   wire  [3:0]  sw_ir;
   wire  [3:0]  sw_v;
   wire  [3:0]  sw_c;
   wire  [3:0]  sw_o;
   wire  [7:0]  s_0;
   wire  [7:0]  s_1;
   wire  [7:0]  s_2;
   wire  [31:0] s_3;

   pipelined_addsub #(.SIZE(8), .STAGES(1)) u_sw0 (
      .clk(clk), .rst(sw_rst), .in_valid(sw_in_valid), .in_ready(sw_ir[0]),
      .a(sw_a[7:0]), .b(sw_b[7:0]), .cin(sw_cin), .sub(sw_sub), .s(s_0),
      .cout(sw_c[0]), .ovf(sw_o[0]), .out_valid(sw_v[0]), .out_ready(sw_out_ready)
   );
   pipelined_addsub #(.SIZE(8), .STAGES(2)) u_sw1 (
      .clk(clk), .rst(sw_rst), .in_valid(sw_in_valid), .in_ready(sw_ir[1]),
      .a(sw_a[7:0]), .b(sw_b[7:0]), .cin(sw_cin), .sub(sw_sub), .s(s_1),
      .cout(sw_c[1]), .ovf(sw_o[1]), .out_valid(sw_v[1]), .out_ready(sw_out_ready)
   );
   pipelined_addsub #(.SIZE(8), .STAGES(8)) u_sw2 (
      .clk(clk), .rst(sw_rst), .in_valid(sw_in_valid), .in_ready(sw_ir[2]),
      .a(sw_a[7:0]), .b(sw_b[7:0]), .cin(sw_cin), .sub(sw_sub), .s(s_2),
      .cout(sw_c[2]), .ovf(sw_o[2]), .out_valid(sw_v[2]), .out_ready(sw_out_ready)
   );
   pipelined_addsub #(.SIZE(32), .STAGES(4)) u_sw3 (
      .clk(clk), .rst(sw_rst), .in_valid(sw_in_valid), .in_ready(sw_ir[3]),
      .a(sw_a), .b(sw_b), .cin(sw_cin), .sub(sw_sub), .s(s_3),
      .cout(sw_c[3]), .ovf(sw_o[3]), .out_valid(sw_v[3]), .out_ready(sw_out_ready)
   );

   int sw_w  [4] = '{8, 8, 8, 32};
   int sw_st [4] = '{1, 2, 8, 4};

   logic [33:0] sw_q   [4][$];
   int          sw_t   [4][$];
   int          sw_acc [4];

   int n_checks = 0;
   int n_fails  = 0;
   int cycle    = 0;

   // Directed vectors: a, b, cin, sub and the expected s, cout, ovf
   logic [15:0] d_a   [11] = '{16'h0000, 16'h0001, 16'd14, 16'd300,
                               16'hFFFF, 16'hFFFF, 16'h7FFF,
                               16'h0005, 16'h0003, 16'h0005, 16'h8000};
   logic [15:0] d_b   [11] = '{16'h0000, 16'h0001, 16'd11, 16'd300,
                               16'hFFFF, 16'h8000, 16'h0001,
                               16'h0003, 16'h0005, 16'h0003, 16'h0001};
   logic        d_cin [11] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0};
   logic        d_sub [11] = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1};
   logic [15:0] d_s   [11] = '{16'd0, 16'd2, 16'd25, 16'd600,
                               16'hFFFE, 16'h7FFF, 16'h8000,
                               16'h0002, 16'hFFFE, 16'h0001, 16'h7FFF};
   logic        d_c   [11] = '{0, 0, 0, 0, 1, 1, 0, 1, 0, 1, 1};
   logic        d_o   [11] = '{0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 1};

   // Reference model: plain integer arithmetic on the operand values.
   // Returns {ovf, cout, s} with s zero-extended to 32 bits.
   function automatic logic [33:0] ref_op(input int w, input logic [31:0] av,
                                          input logic [31:0] bv,
                                          input logic c, input logic sub_op);
      longint m    = (longint'(1) << w) - 1;
      longint half = longint'(1) << (w - 1);
      longint ua   = longint'(av) & m;
      longint ub   = longint'(bv) & m;
      longint sa   = (ua >= half) ? ua - (m + 1) : ua;
      longint sb   = (ub >= half) ? ub - (m + 1) : ub;
      longint cc   = c ? 64'sd1 : 64'sd0;
      longint ur;
      longint sr;
      logic   co;
      logic   ov;
      if (sub_op) begin
         ur = ua - ub - cc;
         sr = sa - sb - cc;
         co = (ur >= 0);
      end else begin
         ur = ua + ub + cc;
         sr = sa + sb + cc;
         co = (ur > m);
      end
      ov = (sr >= half) || (sr < -half);
      return {ov, co, 32'(ur & m)};
   endfunction

   function automatic logic [33:0] swObs(input int i);
      case (i)
         0:       return {sw_o[0], sw_c[0], 24'h0, s_0};
         1:       return {sw_o[1], sw_c[1], 24'h0, s_1};
         2:       return {sw_o[2], sw_c[2], 24'h0, s_2};
         default: return {sw_o[3], sw_c[3], s_3};
      endcase
   endfunction

   // Advance one clock; everything after this samples #1 past the edge.
   task automatic tick;
      @(posedge clk);
      #1;
      cycle++;
   endtask

   task automatic checkOutput(input string tag, input logic [33:0] obs,
                              input logic [33:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fails++;
         $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus(input logic v, input logic [15:0] av,
                                input logic [15:0] bv, input logic c,
                                input logic sb);
      in_valid = v;
      a        = av;
      b        = bv;
      cin      = c;
      sub      = sb;
   endtask

   // Streams n directed ops back to back and expects each result exactly
   // four cycles after acceptance, on consecutive cycles.
   task automatic runDirected(input int lo, input int n);
      for (int t = 0; t <= n + 3; t++) begin
         if (t < n) applyStimulus(1'b1, d_a[lo+t], d_b[lo+t], d_cin[lo+t], d_sub[lo+t]);
         else       applyStimulus(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
         tick();
         if (t < 3) begin
            checkOutput("early_out_valid", 34'(out_valid), 34'd0);
         end else if (t - 3 < n) begin
            checkOutput($sformatf("dir%0d_out_valid", lo + t - 3), 34'(out_valid), 34'd1);
            checkOutput($sformatf("dir%0d_result", lo + t - 3), {16'h0, ovf, cout, s},
                        {16'h0, d_o[lo+t-3], d_c[lo+t-3], d_s[lo+t-3]});
         end else begin
            checkOutput("tail_out_valid", 34'(out_valid), 34'd0);
         end
      end
   endtask

   // One cycle of the sweep: drive, score each instance, advance.
   task automatic sweepCycle(input bit valid_en, input bit bp, input bit chk_lat);
      logic [31:0] mask;
      int          lat;
      sw_in_valid  = valid_en && ($urandom_range(0, 3) != 0);
      sw_a         = $urandom;
      sw_b         = $urandom;
      sw_cin       = 1'($urandom_range(0, 1));
      sw_sub       = 1'($urandom_range(0, 1));
      sw_out_ready = bp ? ($urandom_range(0, 2) != 0) : 1'b1;
      #1;
      for (int i = 0; i < 4; i++) begin
         mask = (sw_w[i] == 32) ? 32'hFFFF_FFFF : ((32'd1 << sw_w[i]) - 32'd1);
         checkOutput($sformatf("sw%0d_in_ready", i), 34'(sw_ir[i]),
                     34'(!sw_v[i] || sw_out_ready));
         if (sw_in_valid && sw_ir[i]) begin
            sw_q[i].push_back(ref_op(sw_w[i], sw_a & mask, sw_b & mask, sw_cin, sw_sub));
            sw_t[i].push_back(cycle);
            sw_acc[i]++;
         end
         if (sw_v[i] && sw_out_ready) begin
            if (sw_q[i].size() == 0) begin
               checkOutput($sformatf("sw%0d_spurious_result", i), 34'd1, 34'd0);
            end else begin
               checkOutput($sformatf("sw%0d_result", i), swObs(i), sw_q[i].pop_front());
               lat = cycle - sw_t[i].pop_front();
               if (chk_lat) checkOutput($sformatf("sw%0d_latency", i), 34'(lat), 34'(sw_st[i]));
            end
         end
      end
      tick();
   endtask

   // Stimulus sequence
   initial begin
      logic [15:0] bp_a [6];
      logic [15:0] bp_b [6];
      logic        bp_c [6];
      logic        bp_s [6];
      logic [33:0] bp_q [$];
      logic [33:0] held;
      int          sent;
      int          got;
      int          cyc;

      $display("[TB] pipelined_addsub bench start");
      rst          = 1'b1;
      out_ready    = 1'b1;
      applyStimulus(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
      sw_rst       = 1'b1;
      sw_in_valid  = 1'b0;
      sw_out_ready = 1'b1;
      sw_a         = '0;
      sw_b         = '0;
      sw_cin       = 1'b0;
      sw_sub       = 1'b0;
      for (int i = 0; i < 4; i++) sw_acc[i] = 0;

      // Power-up reset
      tick();
      tick();
      checkOutput("reset_out_valid", 34'(out_valid), 34'd0);
      checkOutput("reset_result", {16'h0, ovf, cout, s}, 34'd0);
      rst    = 1'b0;
      sw_rst = 1'b0;
      #1;
      checkOutput("reset_in_ready", 34'(in_ready), 34'd1);

      // Streaming add, carry/overflow cases, subtract cases
      runDirected(0, 4);
      runDirected(4, 3);
      runDirected(7, 4);

      // Reset with three ops in flight discards them all
      for (int t = 0; t < 3; t++) begin
         applyStimulus(1'b1, 16'($urandom) | 16'h1234, 16'($urandom) | 16'h4321, 1'b1, 1'(t));
         tick();
      end
      applyStimulus(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
      rst = 1'b1;
      tick();
      checkOutput("midrst_out_valid", 34'(out_valid), 34'd0);
      checkOutput("midrst_result", {16'h0, ovf, cout, s}, 34'd0);
      rst = 1'b0;
      #1;
      checkOutput("midrst_in_ready", 34'(in_ready), 34'd1);
      for (int t = 0; t < 8; t++) begin
         tick();
         checkOutput("midrst_no_result", 34'(out_valid), 34'd0);
      end

      // Backpressure: six ops, out_ready low for five cycles once full
      for (int i = 0; i < 6; i++) begin
         bp_a[i] = 16'($urandom);
         bp_b[i] = 16'($urandom);
         bp_c[i] = 1'($urandom_range(0, 1));
         bp_s[i] = 1'($urandom_range(0, 1));
      end
      sent = 0;
      got  = 0;
      held = '0;
      cyc  = 0;
      while (got < 6 && cyc < 40) begin
         out_ready = !(cyc >= 4 && cyc < 9);
         if (sent < 6) applyStimulus(1'b1, bp_a[sent], bp_b[sent], bp_c[sent], bp_s[sent]);
         else          applyStimulus(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
         #1;
         if (cyc == 4) begin
            checkOutput("bp_full_out_valid", 34'(out_valid), 34'd1);
            held = {16'h0, ovf, cout, s};
         end
         if (cyc >= 4 && cyc < 9) begin
            checkOutput("bp_stall_in_ready", 34'(in_ready), 34'd0);
            if (cyc > 4) begin
               checkOutput("bp_stall_out_valid", 34'(out_valid), 34'd1);
               checkOutput("bp_stall_hold", {16'h0, ovf, cout, s}, held);
            end
         end
         if (in_valid && in_ready) begin
            bp_q.push_back(ref_op(16, 32'(bp_a[sent]), 32'(bp_b[sent]), bp_c[sent], bp_s[sent]));
            sent++;
         end
         if (out_valid && out_ready) begin
            if (bp_q.size() == 0) begin
               checkOutput("bp_spurious_result", 34'd1, 34'd0);
            end else begin
               checkOutput($sformatf("bp_result%0d", got), {ovf, cout, 16'h0, s}, bp_q.pop_front());
            end
            got++;
         end
         tick();
         cyc++;
      end
      checkOutput("bp_results_received", 34'(got), 34'd6);
      applyStimulus(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
      out_ready = 1'b1;
      for (int t = 0; t < 3; t++) begin
         tick();
         checkOutput("bp_no_duplicate", 34'(out_valid), 34'd0);
      end

      // Parameter sweep: streaming with latency checks, then random stalls
      for (int c = 0; c < 3000 && sw_acc[0] < 1000; c++) sweepCycle(1'b1, 1'b0, 1'b1);
      for (int c = 0; c < 12; c++) sweepCycle(1'b0, 1'b0, 1'b1);
      for (int c = 0; c < 800; c++) sweepCycle(1'b1, 1'b1, 1'b0);
      for (int c = 0; c < 20; c++) sweepCycle(1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) begin
         checkOutput($sformatf("sw%0d_drained", i), 34'(sw_q[i].size()), 34'd0);
         checkOutput($sformatf("sw%0d_enough_ops", i), 34'(sw_acc[i] >= 1000), 34'd1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
